puf_resp_serializer: RTL and testbench

Parametrised successor to the PUF response buffer. It captures one wide PUF response word and emits it as a stream of BITS-wide chunks toward the UART/readout path. Unlike the current buffer, it adds:
- ready/valid handshakes on both sides, with backpressure;
- a selectable chunk order (MSB-first or LSB-first);
- zero-padding when DATA_BITS is not a multiple of BITS;
- first/last framing flags;
- zero-gap back-to-back responses.

---
 rtl/puf_resp_serializer.sv | 160 ++++++++++++++++
 tb/tb_puf_resp_serializer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_serializer.sv
// -----------------------------------------------------------------------------
// puf_resp_serializer
//
// Captures one DATA_BITS-wide PUF response through a ready/valid handshake and
// streams it out as NWORDS chunks of BITS bits each. Chunk order is selected
// with MSB_FIRST. A partial final chunk is zero-padded on the side away from
// the data. A new response can be captured in the same cycle that the last
// chunk of the current one transfers, so frames can follow each other with
// no idle cycle between them.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   in_data holds a complete response
//   in_ready   a response can be accepted this cycle (combinational from out_ready)
//   in_data    PUF response, DATA_BITS wide
//   out_valid  out_data holds a valid chunk
//   out_ready  downstream accepts out_data this cycle
//   out_data   current chunk, BITS wide
//   out_first  current chunk is chunk 0
//   out_last   current chunk is chunk NWORDS-1
//   word_idx   index of the current chunk
//   busy       a response is being serialized
// -----------------------------------------------------------------------------
module puf_resp_serializer #(
  parameter int DATA_BITS = 264,
  parameter int BITS      = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int NWORDS   = (DATA_BITS + BITS - 1) / BITS,
  localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      out_data,
  output logic                 out_first,
  output logic                 out_last,
  output logic [CNT_W-1:0]     word_idx,
  output logic                 busy
);

  localparam int TOT = NWORDS * BITS;
  localparam int PAD = TOT - DATA_BITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_r;
  logic [TOT-1:0]    shreg_r;
  logic [CNT_W-1:0]  word_idx_r;
  logic              out_valid_r;
  logic              out_first_r;
  logic              out_last_r;
  logic              capture_s;
  logic              xfer_s;

  // Place the response in the shift register so that chunk 0 sits in the
  // slot out_data reads from; the pad bits end up in the tail of the last chunk.
  function automatic logic [TOT-1:0] pack_resp(input logic [DATA_BITS-1:0] d);
    logic [TOT-1:0] ext;
    ext = '0;
    ext[DATA_BITS-1:0] = d;
    if (MSB_FIRST) begin
      pack_resp = ext << PAD;
    end else begin
      pack_resp = ext;
    end
  endfunction

  // Move the next chunk into the output slot, back-filling with zeros.
  function automatic logic [TOT-1:0] advance(input logic [TOT-1:0] s);
    if (MSB_FIRST) begin
      advance = s << BITS;
    end else begin
      advance = s >> BITS;
    end
  endfunction

  // Ready in IDLE, or in the cycle the last chunk leaves, so frames can chain.
  assign in_ready  = !rst && ((state_r == IDLE) ||
                              ((state_r == SHIFT) && out_last_r && out_ready));
  assign capture_s = in_valid && in_ready;
  assign xfer_s    = out_valid_r && out_ready;

  assign out_valid = out_valid_r;
  assign busy      = out_valid_r;
  assign out_first = out_first_r;
  assign out_last  = out_last_r;
  assign word_idx  = word_idx_r;
  assign out_data  = MSB_FIRST ? shreg_r[TOT-1 -: BITS] : shreg_r[BITS-1:0];

  // Control FSM, shift register and registered framing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shreg_r     <= '0;
      word_idx_r  <= '0;
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            state_r     <= SHIFT;
            shreg_r     <= pack_resp(in_data);
            word_idx_r  <= '0;
            out_valid_r <= 1'b1;
            out_first_r <= 1'b1;
            out_last_r  <= (LAST_IDX == '0);
          end else begin
            state_r     <= IDLE;
          end
        end
        SHIFT: begin
          if (xfer_s && out_last_r) begin
            if (capture_s) begin
              // Chain directly into the next response.
              shreg_r     <= pack_resp(in_data);
              word_idx_r  <= '0;
              out_first_r <= 1'b1;
              out_last_r  <= (LAST_IDX == '0);
            end else begin
              state_r     <= IDLE;
              shreg_r     <= '0;
              word_idx_r  <= '0;
              out_valid_r <= 1'b0;
              out_first_r <= 1'b0;
              out_last_r  <= 1'b0;
            end
          end else if (xfer_s) begin
            shreg_r     <= advance(shreg_r);
            word_idx_r  <= word_idx_r + CNT_W'(1);
            out_first_r <= 1'b0;
            out_last_r  <= ((word_idx_r + CNT_W'(1)) == LAST_IDX);
          end else begin
            // Stalled: every output holds.
            state_r     <= SHIFT;
          end
        end
        default: begin
          state_r     <= IDLE;
          shreg_r     <= '0;
          word_idx_r  <= '0;
          out_valid_r <= 1'b0;
          out_first_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_serializer.sv
module tb_puf_resp_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // d0: 264/8 MSB-first
  logic         d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready;
  logic         d0_out_first, d0_out_last, d0_busy;
  logic [263:0] d0_in_data;
  logic [7:0]   d0_out_data;
  logic [5:0]   d0_word_idx;

  // d1 (MSB-first) and d2 (LSB-first): 20/8, share inputs
  logic        p_in_valid, p_out_ready;
  logic [19:0] p_in_data;
  logic        d1_in_ready, d1_out_valid, d1_out_first, d1_out_last, d1_busy;
  logic [7:0]  d1_out_data;
  logic [1:0]  d1_word_idx;
  logic        d2_in_ready, d2_out_valid, d2_out_first, d2_out_last, d2_busy;
  logic [7:0]  d2_out_data;
  logic [1:0]  d2_word_idx;

  // d3: 8/8 single chunk
  logic       d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
  logic       d3_out_first, d3_out_last, d3_busy;
  logic [7:0] d3_in_data, d3_out_data;
  logic [0:0] d3_word_idx;

  puf_resp_serializer #(.DATA_BITS(264), .BITS(8), .MSB_FIRST(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .in_data(d0_in_data), .out_valid(d0_out_valid), .out_ready(d0_out_ready),
    .out_data(d0_out_data), .out_first(d0_out_first), .out_last(d0_out_last),
    .word_idx(d0_word_idx), .busy(d0_busy));

  puf_resp_serializer #(.DATA_BITS(20), .BITS(8), .MSB_FIRST(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(d1_in_ready),
    .in_data(p_in_data), .out_valid(d1_out_valid), .out_ready(p_out_ready),
    .out_data(d1_out_data), .out_first(d1_out_first), .out_last(d1_out_last),
    .word_idx(d1_word_idx), .busy(d1_busy));

  puf_resp_serializer #(.DATA_BITS(20), .BITS(8), .MSB_FIRST(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(d2_in_ready),
    .in_data(p_in_data), .out_valid(d2_out_valid), .out_ready(p_out_ready),
    .out_data(d2_out_data), .out_first(d2_out_first), .out_last(d2_out_last),
    .word_idx(d2_word_idx), .busy(d2_busy));

  puf_resp_serializer #(.DATA_BITS(8), .BITS(8), .MSB_FIRST(1'b1)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_data(d3_in_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_data(d3_out_data), .out_first(d3_out_first), .out_last(d3_out_last),
    .word_idx(d3_word_idx), .busy(d3_busy));

  // Response whose byte k (from the top) equals base+k.
  function automatic logic [263:0] make_resp(input logic [7:0] base);
    logic [263:0] r;
    r = '0;
    for (int k = 0; k < 33; k++) r[263 - 8*k -: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (d0_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", d0_in_ready);
    end
    checks++;
    if ({d0_out_valid, d0_out_first, d0_out_last, d0_busy, d0_word_idx, d0_out_data} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
        {d0_out_valid, d0_out_first, d0_out_last, d0_busy, d0_word_idx, d0_out_data});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (d0_in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_in_ready: got %b expected 1", d0_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [16:0] got, exp;
    @(negedge clk);
    d0_in_data = make_resp(8'h00); d0_in_valid = 1'b1; d0_out_ready = 1'b1;
    #1;
    checks++;
    if (d0_out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency: got %b expected 0", d0_out_valid);
    end
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      if (k == 0) d0_in_valid = 1'b0;
      #1;
      got = {d0_out_valid, d0_out_first, d0_out_last, d0_word_idx, d0_out_data};
      exp = {1'b1, (k == 0), (k == 32), 6'(k), 8'(k)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL basic_chunk%0d: got %h expected %h", k, got, exp);
      end
      if (k == 32) begin
        checks++;
        if (d0_in_ready !== 1'b1) begin
          errors++; $display("FAIL basic_last_in_ready: got %b expected 1", d0_in_ready);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({d0_out_valid, d0_busy} !== 2'b00) begin
      errors++; $display("FAIL basic_end_idle: got %b expected 00", {d0_out_valid, d0_busy});
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] got, exp;
    int e = 0;
    int cyc = 0;
    @(negedge clk);
    d0_in_data = make_resp(8'h00); d0_in_valid = 1'b1;
    while (e < 33 && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) d0_in_valid = 1'b0;
      d0_out_ready = (cyc % 3 == 0);
      #1;
      got = {d0_out_valid, d0_out_first, d0_out_last, d0_word_idx, d0_out_data};
      exp = {1'b1, (e == 0), (e == 32), 6'(e), 8'(e)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL bp_cycle%0d: got %h expected %h", cyc, got, exp);
      end
      if (d0_out_ready) e++;
      cyc++;
    end
    checks++;
    if (e != 33) begin
      errors++; $display("FAIL bp_count: got %0d expected 33", e);
    end
    @(negedge clk);
    d0_out_ready = 1'b1;
    #1;
    checks++;
    if (d0_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_end_idle: got %b expected 0", d0_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] got, exp;
    int j;
    @(negedge clk);
    d0_in_data = make_resp(8'h00); d0_in_valid = 1'b1; d0_out_ready = 1'b1;
    for (int n = 0; n < 66; n++) begin
      @(negedge clk);
      if (n == 0) d0_in_data = make_resp(8'h40);  // ignored until A's last chunk
      if (n == 33) d0_in_valid = 1'b0;
      #1;
      j = n % 33;
      got = {d0_out_valid, d0_out_first, d0_out_last, d0_word_idx, d0_out_data};
      exp = {1'b1, (j == 0), (j == 32), 6'(j), (n < 33) ? 8'(n) : 8'(8'h40 + j)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_cycle%0d: got %h expected %h", n, got, exp);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (d0_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end_idle: got %b expected 0", d0_out_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [16:0] got, exp;
    @(negedge clk);
    d0_in_data = make_resp(8'h00); d0_in_valid = 1'b1; d0_out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) d0_in_valid = 1'b0;
      #1;
      got = {d0_out_valid, d0_out_first, d0_out_last, d0_word_idx, d0_out_data};
      exp = {1'b1, (k == 0), 1'b0, 6'(k), 8'(k)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rstmid_chunk%0d: got %h expected %h", k, got, exp);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (d3_in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_ready_in_reset: got %b expected 0", d3_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({d0_out_valid, d0_busy, d0_out_first, d0_out_last, d0_word_idx, d0_out_data} !== 18'h0) begin
      errors++; $display("FAIL rstmid_cleared: got %h expected 0",
        {d0_out_valid, d0_busy, d0_out_first, d0_out_last, d0_word_idx, d0_out_data});
    end
    d0_in_data = make_resp(8'h40); d0_in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d0_in_valid = 1'b0;
      #1;
      got = {d0_out_valid, d0_out_first, d0_out_last, d0_word_idx, d0_out_data};
      exp = {1'b1, (k == 0), 1'b0, 6'(k), 8'(8'h40 + k)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rstmid_restart%0d: got %h expected %h", k, got, exp);
      end
    end
    repeat (32) @(negedge clk);
    #1;
    checks++;
    if (d0_out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_end_idle: got %b expected 0", d0_out_valid);
    end
  endtask

  task automatic test_padding();
    logic [7:0]  msb_exp [3];
    logic [7:0]  lsb_exp [3];
    logic [12:0] got, exp;
    msb_exp = '{8'hAB, 8'hCD, 8'hE0};
    lsb_exp = '{8'hDE, 8'hBC, 8'h0A};
    @(negedge clk);
    p_in_data = 20'hABCDE; p_in_valid = 1'b1; p_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      p_in_valid = 1'b0;
      #1;
      got = {d1_out_valid, d1_out_first, d1_out_last, d1_word_idx, d1_out_data};
      exp = {1'b1, (k == 0), (k == 2), 2'(k), msb_exp[k]};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pad_msb_chunk%0d: got %h expected %h", k, got, exp);
      end
      got = {d2_out_valid, d2_out_first, d2_out_last, d2_word_idx, d2_out_data};
      exp = {1'b1, (k == 0), (k == 2), 2'(k), lsb_exp[k]};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL pad_lsb_chunk%0d: got %h expected %h", k, got, exp);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({d1_out_valid, d2_out_valid} !== 2'b00) begin
      errors++; $display("FAIL pad_end_idle: got %b expected 00", {d1_out_valid, d2_out_valid});
    end
  endtask

  task automatic test_single_word();
    logic [11:0] got;
    @(negedge clk);
    d3_in_data = 8'h5A; d3_in_valid = 1'b1; d3_out_ready = 1'b1;
    @(negedge clk);
    d3_in_valid = 1'b0;
    #1;
    got = {d3_out_valid, d3_out_first, d3_out_last, d3_word_idx, d3_out_data};
    checks++;
    if (got !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h5A}) begin
      errors++; $display("FAIL single_chunk: got %h expected %h", got, 12'hE5A);
    end
    @(negedge clk); #1;
    checks++;
    if ({d3_out_valid, d3_busy, d3_in_ready} !== 3'b001) begin
      errors++; $display("FAIL single_end_idle: got %b expected 001",
        {d3_out_valid, d3_busy, d3_in_ready});
    end
  endtask

  initial begin
    rst = 1'b1;
    d0_in_valid = 1'b0; d0_in_data = '0; d0_out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b1;
    d3_in_valid = 1'b0; d3_in_data = '0; d3_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_padding();
    test_single_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
